// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: fixed-latency accesses, pipeline
// stall while an access is in flight, one-cycle error flag in the response cycle.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        err_o
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q, wdata_q;
  logic          rd_q, wr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req, commit;
  logic [31:0]   op_addr, op_wdata;
  logic          op_rd, op_wr;
  logic [29:0]   op_idx;
  logic          misaligned, out_of_range, bad_addr, op_err;

  assign req = MemRead_i | MemWrite_i;

  // With LATENCY=1 the commit happens on the accepting edge, so the live
  // request is used; otherwise the copy latched at acceptance is used.
  assign op_addr      = (state == S_IDLE) ? addr_i     : addr_q;
  assign op_wdata     = (state == S_IDLE) ? data_i     : wdata_q;
  assign op_rd        = (state == S_IDLE) ? MemRead_i  : rd_q;
  assign op_wr        = (state == S_IDLE) ? MemWrite_i : wr_q;
  assign op_idx       = op_addr[31:2];
  assign misaligned   = |op_addr[1:0];
  assign out_of_range = (op_idx >= 30'(DEPTH_WORDS));
  assign bad_addr     = misaligned | out_of_range;
  assign op_err       = bad_addr | (op_rd & op_wr);
  assign commit       = (state_nxt == S_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          stall_o   = 1'b1;
          state_nxt = (LATENCY == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (cnt == CW'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (rst_i) stall_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      data_o  <= '0;
      err_o   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      err_o <= 1'b0;
      if (state == S_IDLE && req) begin
        addr_q  <= addr_i;
        wdata_q <= data_i;
        rd_q    <= MemRead_i;
        wr_q    <= MemWrite_i;
        cnt     <= CW'(LATENCY - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CW'(1);
      end
      // A dual request is treated as a write; data_o only moves on reads.
      if (commit) begin
        err_o <= op_err;
        if (op_wr) begin
          if (!bad_addr) mem[op_idx[AW-1:0]] <= op_wdata;
        end else if (op_rd) begin
          data_o <= bad_addr ? '0 : mem[op_idx[AW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table vectors, hand-written timing sequences
// and randomized accesses against an array-based reference model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd3, wr3, rd1, wr1;
  logic [31:0] addr3, wd3, addr1, wd1;
  logic [31:0] dout3, dout1;
  logic        stall3, stall1, err3, err1;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [128];
  logic [31:0] ref_data;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [13];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(3)) dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd3), .MemWrite_i(wr3),
    .addr_i(addr3), .data_i(wd3), .data_o(dout3), .stall_o(stall3), .err_o(err3)
  );

  data_mem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .data_i(wd1), .data_o(dout1), .stall_o(stall1), .err_o(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; wd1 = d; end
    else     begin rd3 = rd; wr3 = wr; addr3 = a; wd3 = d; end
  endtask

  function automatic logic cur_stall(input bit sel);
    return sel ? stall1 : stall3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    ref_data = '0;
  endtask

  task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, output bit err, output logic [31:0] data);
    bit bad;
    int idx;
    bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'd128);
    idx = bad ? 0 : int'(a[31:2]);
    err = bad || (rd && wr);
    if (wr) begin
      if (!bad) ref_mem[idx] = d;
    end else if (rd) begin
      ref_data = bad ? 32'h0 : ref_mem[idx];
    end
    data = ref_data;
  endtask

  // Entered at posedge+1; the request is held until the response cycle ends.
  task automatic access(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input bit exp_err,
                        input logic [31:0] exp_data, input string name);
    int n;
    n = 0;
    drive(sel, rd, wr, a, d);
    @(negedge clk);
    while (cur_stall(sel) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({name, " stall_cycles"}, n, lat);
    chk({name, " err"}, sel ? err1 : err3, {31'b0, exp_err});
    chk({name, " data"}, sel ? dout1 : dout3, exp_data);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk({name, " err_after"}, sel ? err1 : err3, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          e;
    logic [31:0] dm;

    tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h12,  32'hFF,       1'b1, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h14,  32'h55,       1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h14,  32'h0,        1'b0, 32'h55};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,   32'h11,       1'b0, 32'h55};
    tbl[8]  = '{1'b0, 1'b1, 32'h4,   32'h22,       1'b0, 32'h55};
    tbl[9]  = '{1'b0, 1'b1, 32'h1FC, 32'hCAFEF00D, 1'b0, 32'h55};
    tbl[10] = '{1'b1, 1'b0, 32'h1FC, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[11] = '{1'b0, 1'b1, 32'h200, 32'h77,       1'b1, 32'hCAFEF00D};
    tbl[12] = '{1'b1, 1'b0, 32'h3,   32'h0,        1'b1, 32'h0};

    model_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, '0);
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall3", stall3, 32'h0);
    chk("reset stall1", stall1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("reset data", dout3, 32'h0);
    chk("reset err", err3, 32'h0);
    chk("reset idle stall", stall3, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      model_apply(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, e, dm);
      access(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 3,
             tbl[i].err, tbl[i].data, $sformatf("tbl%0d", i));
    end

    // Back-to-back reads with the request held straight through the first DONE.
    drive(1'b0, 1'b1, 1'b0, 32'h0, '0);
    for (int c = 0; c < 8; c++) begin
      if (c == 4) drive(1'b0, 1'b1, 1'b0, 32'h4, '0);
      @(negedge clk);
      chk($sformatf("b2b stall c%0d", c), stall3, (c == 3 || c == 7) ? 32'h0 : 32'h1);
      if (c == 3) begin
        chk("b2b data1", dout3, 32'h11);
        chk("b2b err1", err3, 32'h0);
      end
      if (c == 7) begin
        chk("b2b data2", dout3, 32'h22);
        chk("b2b err2", err3, 32'h0);
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    model_apply(1'b1, 1'b0, 32'h0, '0, e, dm);
    model_apply(1'b1, 1'b0, 32'h4, '0, e, dm);

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle stall", stall3, 32'h0);
      chk("idle err", err3, 32'h0);
      chk("idle data", dout3, ref_data);
      @(posedge clk); #1;
    end

    access(1'b1, 1'b0, 1'b1, 32'h8, 32'hA5, 1, 1'b0, 32'h0,  "l1 wr");
    access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0,  1, 1'b0, 32'hA5, "l1 rd");
    access(1'b1, 1'b1, 1'b0, 32'h9, 32'h0,  1, 1'b1, 32'h0,  "l1 misaligned rd");

    for (int i = 0; i < 40; i++) begin
      int          k, o, gap;
      bit          r, w;
      logic [31:0] a, d;
      k = int'($urandom_range(0, 9));
      o = int'($urandom_range(0, 4));
      d = $urandom;
      if (k < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (k == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(128, 1000)) << 2;
      r = (o <= 1) || (o == 4);
      w = (o >= 2);
      model_apply(r, w, a, d, e, dm);
      access(1'b0, r, w, a, d, 3, e, dm, $sformatf("rnd%0d", i));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rnd gap stall", stall3, 32'h0);
        @(posedge clk); #1;
      end
    end

    // Reset lands in the second cycle of a write; nothing may commit.
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234);
    @(negedge clk);
    chk("rstmid stall c0", stall3, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid stall in reset", stall3, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk);
    chk("rstmid stall after", stall3, 32'h0);
    chk("rstmid data", dout3, 32'h0);
    chk("rstmid err", err3, 32'h0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'h20, '0, 3, 1'b0, 32'h0, "rstmid rd");
    access(1'b0, 1'b1, 1'b0, 32'h10, '0, 3, 1'b0, 32'h0, "rstmid cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipelined CPU's MEM-stage data port. It accepts the CPU's existing request signals (`addr_i`, `data_i`, `MemRead_i`, `MemWrite_i`) and services each access with a fixed, parameterised latency. While an access is in flight it drives `stall_o`, which holds PC, IF/ID, ID/EX and EX/MEM in place. It is the multi-cycle replacement for the single-cycle data memory and sits between the EX/MEM and MEM/WB registers.

## Interface
- `DEPTH_WORDS`, default 128: number of 32-bit words stored. Word index is `addr_i[31:2]`.
- `LATENCY`, default 3: cycles from request acceptance until the response cycle. Must be ≥1.
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `MemRead_i` in 1: read request. Level-held by the CPU until the response cycle.
- `MemWrite_i` in 1: write request. Level-held by the CPU until the response cycle.
- `addr_i` in 32: byte address; must be word-aligned.
- `data_i` in 32: write data.
- `data_o` out 32: read data. Registered; holds its value between reads.
- `stall_o` out 1: pipeline hold. Combinational from state and request.
- `err_o` out 1: one-cycle error flag, raised in the response cycle.

## Operation
- State machine: IDLE, WAIT, DONE.
- **IDLE**
  - A request is `req = MemRead_i | MemWrite_i`.
  - When `req=1`: latch address, write data and op type; load `cnt = LATENCY-1`.
  - If `LATENCY=1`, go to DONE; otherwise go to WAIT.
- **WAIT**
  - `cnt` decrements each cycle.
  - When `cnt==1`, go to DONE on that edge.
  - Inputs are ignored while in WAIT; the latched copy is used.
- **DONE**
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
  - The request still present in this cycle belongs to the finished access and is never re-accepted.
- **Commit**
  - Happens on the edge that enters DONE.
  - Write: `mem[idx] <= wdata`.
  - Read: `data_o <= mem[idx]`.
- **stall_o**
  - Equals `(IDLE & req) | WAIT`.
  - Low in DONE, so the pipeline advances during the response cycle.
  - Forced to 0 while `rst_i=1`.
- **Errors** (`err_o=1` in DONE; full latency still applies)
  - Misaligned address (`addr_i[1:0]≠0`): write suppressed; read loads `data_o=0`.
  - Out-of-range address (`addr_i[31:2] ≥ DEPTH_WORDS`): write suppressed; read loads `data_o=0`.
  - Both `MemRead_i` and `MemWrite_i` high: performed as a write, and `err_o=1`.
- **Reset**
  - On a clock edge with `rst_i=1`: state to IDLE, `cnt=0`, `data_o=0`, `err_o=0`, every memory word cleared to 0.
  - Reset mid-access aborts it: no write commit, no response cycle.

## Timing
- Request first visible in cycle 0 (state IDLE): `stall_o=1` in cycles 0 to LATENCY-1.
- Cycle LATENCY is DONE: `stall_o=0`, `data_o` valid (reads), `err_o` valid.
- Cycle LATENCY+1 is IDLE again. A new request there stalls in that same cycle.
- Throughput: one access per LATENCY+1 cycles.
- Back-to-back requests incur one idle cycle between them, which is the DONE-to-IDLE transition.
- `data_o` is stable from the DONE cycle until the next read commits; writes do not change it.
- Non-memory instructions (`req=0`) see `stall_o=0` and no extra latency.

## Test plan
- **Write then read, LATENCY=3**
  - Stimulus: write `0xDEADBEEF` to `0x10`, then read `0x10`.
  - Required: `stall_o` high for 3 cycles on each access; in the read's DONE cycle `data_o=0xDEADBEEF`, `err_o=0`.
- **Back-to-back reads**
  - Stimulus: read `0x0` and `0x4`, preloaded with `0x11` and `0x22`.
  - Required: first DONE at cycle 3 with `data_o=0x11`; second request accepted at cycle 4; second DONE at cycle 7 with `data_o=0x22`; no re-acceptance in either DONE cycle.
- **LATENCY=1 build**
  - Stimulus: write `0xA5` to `0x8`, then read `0x8`.
  - Required: `stall_o` high for exactly 1 cycle per access; read returns `0xA5`.
- **Error cases**
  - Misaligned write: write `0xFF` to `0x12` gives `err_o=1` in DONE; a later read of `0x10` returns the prior value.
  - Out-of-range read: read `0x200` with `DEPTH_WORDS=128` gives `data_o=0`, `err_o=1`.
  - Dual op: `MemRead_i=MemWrite_i=1` writes `data_i` and raises `err_o=1`.
- **Reset mid-write**
  - Stimulus: assert `rst_i` in cycle 1 of a write of `0x1234` to `0x20`.
  - Required: `stall_o=0` during reset; state returns to IDLE; a later read of `0x20` returns `0`.
- **Non-memory traffic**
  - Stimulus: `req=0` for 10 cycles.
  - Required: `stall_o` stays 0, `err_o` stays 0, `data_o` unchanged.
